// File: rtl/frame_backlight_statistics.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : frame_backlight_statistics                                 |
// | Description : Per-frame peak/mean luminance statistics with a 10-bit     |
// |               backlight value derived at every vsync frame boundary.     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module frame_backlight_statistics #(
  parameter int         CNT_WIDTH         = 22,
  parameter bit         VSYNC_ACTIVE_HIGH = 1'b1,
  parameter logic [9:0] MIN_PWM           = 10'd64
) (
  input  logic       p_clock_from_decoder,
  input  logic       reset,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic       de_in,
  input  logic       vsync_in,
  input  logic [1:0] mode,
  output logic [9:0] pwm_value,
  output logic [7:0] frame_max,
  output logic [7:0] frame_mean,
  output logic       stats_valid,
  output logic       busy,
  output logic       sat
);

  localparam int                   SUM_W     = CNT_WIDTH + 8;
  localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  // Stage S1 registers
  logic [7:0] r_q, g_q, b_q;
  logic       de_q, vs_q, vs_q2;
  logic       vs_norm;

  // Frame accumulators
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           rmax_q, rmax_d;
  logic                 fsat_q, fsat_d;
  logic [7:0]           y_w;
  logic                 acc_en;
  logic                 boundary;

  // Divider / snapshot
  state_t               state_q, state_d;
  logic [2:0]           k_q, k_d;
  logic [SUM_W-1:0]     rem_q, rem_d;
  logic [CNT_WIDTH-1:0] dcnt_q, dcnt_d;
  logic [7:0]           quo_q, quo_d;
  logic [7:0]           smax_q, smax_d;
  logic                 ssat_q, ssat_d;
  logic [SUM_W-1:0]     trial;

  // Published outputs
  logic [9:0] pwm_q, pwm_d;
  logic [7:0] fmax_q, fmax_d;
  logic [7:0] fmean_q, fmean_d;
  logic       osat_q, osat_d;
  logic       valid_q, valid_d;

  // Maps the selected 8-bit statistic to 10 bits by replication, then floors it.
  function automatic logic [9:0] map_pwm(input logic [1:0] m,
                                         input logic [7:0] mx,
                                         input logic [7:0] mn);
    logic [8:0] s;
    logic [7:0] v;
    logic [9:0] v10;
    s = {1'b0, mx} + {1'b0, mn};
    v = s[8:1];
    case (m)
      2'd1:    v = mx;
      2'd2:    v = mn;
      default: v = s[8:1];
    endcase
    v10 = (m == 2'd0) ? 10'd1023 : {v, v[7:6]};
    return (v10 < MIN_PWM) ? MIN_PWM : v10;
  endfunction

  assign vs_norm  = VSYNC_ACTIVE_HIGH ? vsync_in : ~vsync_in;
  assign boundary = vs_q & ~vs_q2;
  assign y_w      = (r_q >= g_q) ? ((r_q >= b_q) ? r_q : b_q)
                                 : ((g_q >= b_q) ? g_q : b_q);
  assign acc_en   = de_q && (cnt_q != C_CNT_MAX);

  // S1: register pixel inputs and the polarity-normalised vsync history.
  always_ff @(posedge p_clock_from_decoder) begin
    if (reset) begin
      r_q   <= 8'd0;
      g_q   <= 8'd0;
      b_q   <= 8'd0;
      de_q  <= 1'b0;
      vs_q  <= 1'b0;
      vs_q2 <= 1'b0;
    end else begin
      r_q   <= r_in;
      g_q   <= g_in;
      b_q   <= b_in;
      de_q  <= de_in;
      vs_q  <= vs_norm;
      vs_q2 <= vs_q;
    end
  end

  // S2: next accumulator values; count and sum freeze once count saturates.
  always_comb begin
    sum_d  = sum_q;
    cnt_d  = cnt_q;
    rmax_d = rmax_q;
    fsat_d = fsat_q;
    if (acc_en) begin
      sum_d = sum_q + SUM_W'(y_w);
      cnt_d = cnt_q + CNT_WIDTH'(1);
      if (y_w > rmax_q) rmax_d = y_w;
      if (cnt_d == C_CNT_MAX) fsat_d = 1'b1;
    end
  end

  // S2: accumulators restart on every boundary, even if the divider is busy.
  always_ff @(posedge p_clock_from_decoder) begin
    if (reset || boundary) begin
      sum_q  <= '0;
      cnt_q  <= '0;
      rmax_q <= 8'd0;
      fsat_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cnt_q  <= cnt_d;
      rmax_q <= rmax_d;
      fsat_q <= fsat_d;
    end
  end

  // Never overflows: count << 7 needs at most CNT_WIDTH+7 bits.
  assign trial = SUM_W'(dcnt_q) << k_q;

  // FSM next state: snapshot in IDLE, one quotient bit per DIVIDE cycle, publish in UPDATE.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    rem_d   = rem_q;
    dcnt_d  = dcnt_q;
    quo_d   = quo_q;
    smax_d  = smax_q;
    ssat_d  = ssat_q;
    pwm_d   = pwm_q;
    fmax_d  = fmax_q;
    fmean_d = fmean_q;
    osat_d  = osat_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (boundary) begin
          // Snapshot uses the _d values so a pixel landing on this edge counts.
          rem_d   = sum_d;
          dcnt_d  = cnt_d;
          smax_d  = rmax_d;
          ssat_d  = fsat_d;
          quo_d   = 8'd0;
          k_d     = 3'd7;
          state_d = S_DIVIDE;
        end
      end
      S_DIVIDE: begin
        // An empty frame never subtracts, leaving a zero quotient.
        if ((dcnt_q != '0) && (rem_q >= trial)) begin
          rem_d      = rem_q - trial;
          quo_d[k_q] = 1'b1;
        end
        if (k_q == 3'd0) state_d = S_UPDATE;
        else             k_d     = k_q - 3'd1;
      end
      S_UPDATE: begin
        fmax_d  = smax_q;
        fmean_d = quo_q;
        osat_d  = ssat_q;
        pwm_d   = map_pwm(mode, smax_q, quo_q);
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM, divider and output registers.
  always_ff @(posedge p_clock_from_decoder) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
      rem_q   <= '0;
      dcnt_q  <= '0;
      quo_q   <= 8'd0;
      smax_q  <= 8'd0;
      ssat_q  <= 1'b0;
      pwm_q   <= 10'd1023;
      fmax_q  <= 8'd0;
      fmean_q <= 8'd0;
      osat_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      rem_q   <= rem_d;
      dcnt_q  <= dcnt_d;
      quo_q   <= quo_d;
      smax_q  <= smax_d;
      ssat_q  <= ssat_d;
      pwm_q   <= pwm_d;
      fmax_q  <= fmax_d;
      fmean_q <= fmean_d;
      osat_q  <= osat_d;
      valid_q <= valid_d;
    end
  end

  assign pwm_value   = pwm_q;
  assign frame_max   = fmax_q;
  assign frame_mean  = fmean_q;
  assign stats_valid = valid_q;
  assign sat         = osat_q;
  // Busy spans DIVIDE, UPDATE and the cycle in which the new results are shown.
  assign busy        = (state_q != S_IDLE) | valid_q;

endmodule
`default_nettype wire
